// File: rtl/genius_input_arbiter.sv
// genius_input_arbiter: debounced key / IR colour arbiter with valid-ack handoff and post-accept lockout
// Ports: clk_pll, reset (async, active-high); key_n[3:0] raw active-low buttons (bit = colour);
// ir_ready/ir_cor IR colour strobe; accept_en player-input phase; cor_ack event consumed;
// cor_out/cor_valid/src held event (src 1 = IR); busy in HOLD or LOCKOUT;
// drop_cnt saturating discarded-event count, live only with GENIUS_ARB_DROPCNT_EN defined, else 0.
module genius_input_arbiter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LOCKOUT_CYCLES  = 5000000
) (
  input  logic       clk_pll,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       ir_ready,
  input  logic [1:0] ir_cor,
  input  logic       accept_en,
  input  logic       cor_ack,
  output logic [1:0] cor_out,
  output logic       cor_valid,
  output logic       src,
  output logic       busy,
  output logic [7:0] drop_cnt
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, HOLD, LOCKOUT} state_t;
  state_t state, state_nx;
  logic [3:0] sync1, sync2, deb, deb_q, press;
  logic [DW-1:0] dcnt [4];
  logic [LW-1:0] lcnt;
  logic [1:0] key_cor;
  logic any_key, take;
  always_ff @(posedge clk_pll or posedge reset)
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      deb_q <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      deb_q <= deb;
    end
  // counter runs only while the synchronised level disagrees; DEBOUNCE_CYCLES such cycles in a row commit it
  always_ff @(posedge clk_pll or posedge reset)
    if (reset) begin
      deb <= '1;
      for (int i = 0; i < 4; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (sync2[i] == deb[i]) dcnt[i] <= '0;
        else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          dcnt[i] <= '0;
          deb[i] <= sync2[i];
        end else dcnt[i] <= dcnt[i] + DW'(1);
    end
  assign press   = deb_q & ~deb;
  assign any_key = |press;
  assign key_cor = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
  always_comb begin
    state_nx = state;
    take = 1'b0;
    case (state)
      IDLE:    if (accept_en && (any_key || ir_ready)) begin
                 take = 1'b1;
                 state_nx = HOLD;
               end
      HOLD:    if (cor_ack || !accept_en) state_nx = LOCKOUT;
      LOCKOUT: if (lcnt == LW'(LOCKOUT_CYCLES) && &deb) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // lcnt idles at 0 outside LOCKOUT, so it is already cleared on entry
  always_ff @(posedge clk_pll or posedge reset)
    if (reset) begin
      state <= IDLE;
      lcnt <= '0;
      cor_out <= '0;
      src <= 1'b0;
    end else begin
      state <= state_nx;
      lcnt <= state != LOCKOUT ? '0 : lcnt == LW'(LOCKOUT_CYCLES) ? lcnt : lcnt + LW'(1);
      if (take) begin
        cor_out <= any_key ? key_cor : ir_cor;
        src <= !any_key;
      end
    end
  assign cor_valid = state == HOLD;
  assign busy      = state != IDLE;
`ifdef GENIUS_ARB_DROPCNT_EN
  logic [2:0] n_ev, n_drop;
  logic [8:0] drop_sum;
  // every event not latched is a drop, plus one for an event withdrawn by accept_en falling in HOLD
  assign n_ev     = 3'(press[0]) + 3'(press[1]) + 3'(press[2]) + 3'(press[3]) + 3'(ir_ready);
  assign n_drop   = n_ev - 3'(take) + 3'(state == HOLD && !cor_ack && !accept_en);
  assign drop_sum = {1'b0, drop_cnt} + {6'd0, n_drop};
  always_ff @(posedge clk_pll or posedge reset)
    if (reset) drop_cnt <= '0;
    else drop_cnt <= drop_sum[8] ? 8'hff : drop_sum[7:0];
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_genius_input_arbiter.sv
// tb_genius_input_arbiter: randomized and directed check of genius_input_arbiter against a window-based reference model
module tb_genius_input_arbiter;
  localparam int DEB = 4;
  localparam int LOCK = 8;
  logic clk_pll = 1'b0, reset = 1'b1;
  logic [3:0] key_n = 4'hf;
  logic ir_ready = 1'b0, accept_en = 1'b0, cor_ack = 1'b0;
  logic [1:0] ir_cor = 2'd0;
  logic [1:0] cor_out;
  logic cor_valid, src, busy;
  logic [7:0] drop_cnt;
  int n_cmp = 0, n_bad = 0;
  always #5 clk_pll = ~clk_pll;
  genius_input_arbiter #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK)) dut (
    .clk_pll(clk_pll), .reset(reset), .key_n(key_n), .ir_ready(ir_ready), .ir_cor(ir_cor),
    .accept_en(accept_en), .cor_ack(cor_ack), .cor_out(cor_out), .cor_valid(cor_valid),
    .src(src), .busy(busy), .drop_cnt(drop_cnt));
  logic [3:0] hist[$];
  logic [3:0] m_deb, m_fell;
  int last_flip[4];
  int edge_no, m_lock, m_drops;
  bit m_pend, m_src;
  logic [1:0] m_cor;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] exp_drop();
`ifdef GENIUS_ARB_DROPCNT_EN
    return 8'(m_drops);
`else
    return 8'd0;
`endif
  endfunction
  function automatic bit sync_bit(input int k, input int i);
    logic [3:0] v;
    v = k >= 2 ? hist[k-2] : 4'hf;
    return v[i];
  endfunction
  task automatic model_reset();
    hist.delete();
    m_deb = 4'hf;
    m_fell = 4'h0;
    for (int i = 0; i < 4; i++) last_flip[i] = -100;
    edge_no = 0;
    m_pend = 0;
    m_lock = -1;
    m_cor = 2'd0;
    m_src = 0;
    m_drops = 0;
  endtask
  task automatic model_edge();
    int n_ev;
    logic [3:0] nd;
    bit stable;
    n_ev = $countones(m_fell) + int'(ir_ready);
    if (!m_pend && m_lock < 0) begin
      if (accept_en && n_ev > 0) begin
        m_pend = 1;
        m_src = m_fell == 4'h0;
        m_cor = ir_cor;
        for (int i = 3; i >= 0; i--) if (m_fell[i]) m_cor = 2'(i);
        m_drops += n_ev - 1;
      end else m_drops += n_ev;
    end else if (m_pend) begin
      m_drops += n_ev;
      if (cor_ack || !accept_en) begin
        m_drops += int'(!cor_ack);
        m_pend = 0;
        m_lock = 0;
      end
    end else begin
      m_drops += n_ev;
      if (m_lock >= LOCK && m_deb == 4'hf) m_lock = -1;
      else m_lock++;
    end
    if (m_drops > 255) m_drops = 255;
    nd = m_deb;
    for (int i = 0; i < 4; i++) begin
      stable = edge_no - last_flip[i] >= DEB;
      for (int j = 0; j < DEB; j++) if (sync_bit(edge_no - j, i) == m_deb[i]) stable = 0;
      if (stable) begin
        nd[i] = ~m_deb[i];
        last_flip[i] = edge_no;
      end
    end
    m_fell = m_deb & ~nd;
    m_deb = nd;
    hist.push_back(key_n);
    edge_no++;
  endtask
  task automatic step();
    @(posedge clk_pll);
    model_edge();
    #1;
    check("outputs", {19'd0, cor_out, cor_valid, src, busy, drop_cnt},
          {19'd0, m_cor, m_pend, m_src, m_lock >= 0 || m_pend, exp_drop()});
  endtask
  task automatic wait_valid(output int k);
    k = 0;
    for (int c = 1; c <= 30 && k == 0; c++) begin
      step();
      if (cor_valid) k = c;
    end
  endtask
  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step();
  endtask
  task automatic ack();
    cor_ack = 1'b1;
    step();
    cor_ack = 1'b0;
  endtask
  initial begin
    int k, rises, bad;
    logic [7:0] d0;
    bit prev;
    model_reset();
    #12;
    check("reset_state", {19'd0, cor_out, cor_valid, src, busy, drop_cnt}, 32'd0);
    @(negedge clk_pll);
    reset = 1'b0;
    idle(3);
    accept_en = 1'b1;
    idle(2);
    key_n = 4'b1011;
    wait_valid(k);
    check("key_latency", k, 7);
    check("key_cor", {cor_out, src}, {2'd2, 1'b0});
    ack();
    check("ack_clears", {cor_valid, busy}, 2'b01);
    key_n = 4'hf;
    idle(12);
    check("lock_done", busy, 0);
    for (int c = 0; c < 10; c++) begin
      key_n[1] = (c / 2) % 2 != 0;
      step();
    end
    key_n[1] = 1'b0;
    wait_valid(k);
    check("bounce_found", k != 0, 1);
    check("bounce_cor", cor_out, 2'd1);
    ack();
    rises = 0;
    prev = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (cor_valid && !prev) rises++;
      prev = cor_valid;
    end
    check("bounce_once", rises, 0);
    key_n = 4'hf;
    idle(12);
    d0 = exp_drop();
    ir_ready = 1'b1;
    ir_cor = 2'd3;
    step();
    ir_ready = 1'b0;
    check("ir_event", {cor_valid, cor_out, src}, {1'b1, 2'd3, 1'b1});
    ack();
    idle(2);
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
`ifdef GENIUS_ARB_DROPCNT_EN
    check("ir_drop", drop_cnt, d0 + 8'd1);
`else
    check("ir_drop", drop_cnt, 8'd0);
`endif
    check("ir_drop_valid", cor_valid, 0);
    idle(12);
    d0 = exp_drop();
    key_n = 4'b1110;
    idle(6);
    ir_ready = 1'b1;
    ir_cor = 2'd2;
    step();
    ir_ready = 1'b0;
    check("collide_cor", {cor_valid, cor_out, src}, {1'b1, 2'd0, 1'b0});
`ifdef GENIUS_ARB_DROPCNT_EN
    check("collide_drop", drop_cnt, d0 + 8'd1);
`else
    check("collide_drop", drop_cnt, 8'd0);
`endif
    ack();
    key_n = 4'hf;
    idle(12);
    key_n = 4'b0111;
    wait_valid(k);
    check("held_found", k != 0, 1);
    ack();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (!busy || cor_valid) bad++;
    end
    check("held_lockout", bad, 0);
    key_n = 4'hf;
    k = 0;
    for (int c = 1; c <= 20 && k == 0; c++) begin
      step();
      if (!busy) k = c;
    end
    check("held_release", k != 0, 1);
    ir_ready = 1'b1;
    ir_cor = 2'd1;
    step();
    ir_ready = 1'b0;
    check("pre_reset_hold", cor_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_hold", {19'd0, cor_out, cor_valid, src, busy, drop_cnt}, 32'd0);
    model_reset();
    @(negedge clk_pll);
    reset = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) key_n[i] = ~key_n[i];
      ir_ready = $urandom_range(4) == 0;
      ir_cor = 2'($urandom_range(3));
      accept_en = $urandom_range(9) != 0;
      cor_ack = $urandom_range(3) == 0;
      if (c == 1200) begin
        #2;
        reset = 1'b1;
        #1;
        check("reset_random", {19'd0, cor_out, cor_valid, src, busy, drop_cnt}, 32'd0);
        model_reset();
        @(negedge clk_pll);
        reset = 1'b0;
      end
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/genius_input_arbiter.md
# genius_input_arbiter

Arbitrates the player colour-input channel of the Genius game between the four front-panel push buttons and the IR remote decoder (`remote`), delivering one colour event at a time to the game FSM over a valid/ack handshake. It synchronises and debounces the keys, applies fixed priority on collisions, and enforces a post-acceptance lockout so one physical press or IR burst yields exactly one event. It sits between the input front-ends (`remote`, board keys) and the game sequencer, in the `clk_pll` domain.

## Interface
- `DEBOUNCE_CYCLES`, 500000: cycles a synchronised key level must hold stable before the debounced level changes (10 ms at 50 MHz).
- `LOCKOUT_CYCLES`, 5000000: minimum cycles after an accepted event before the next event is accepted (100 ms at 50 MHz).
- `clk_pll`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `key_n`  in  4  raw active-low push buttons; bit i is colour i (0 green, 1 red, 2 yellow, 3 blue).
- `ir_ready`  in  1  one-cycle strobe from `remote`: `ir_cor` is valid.
- `ir_cor`  in  2  colour code from `remote`, same encoding as `key_n` bits.
- `accept_en`  in  1  game FSM is in the player-input phase.
- `cor_ack`  in  1  game FSM consumed `cor_out`.
- `cor_out`  out  2  accepted colour.
- `cor_valid`  out  1  `cor_out` holds an unconsumed event.
- `src`  out  1  source of current event: 0 keys, 1 IR.
- `busy`  out  1  high in HOLD or LOCKOUT.
- `drop_cnt`  out  8  saturating count of discarded events (see Configuration).

## Operation
- Key front-end per bit: 2-FF synchroniser, then counter of width clog2(DEBOUNCE_CYCLES+1); counter clears whenever synchronised level differs from debounced level is false, otherwise increments; on reaching DEBOUNCE_CYCLES the debounced level takes the synchronised level. Debounced reset value 1 (released). Press event = debounced 1→0 transition, one cycle.
- FSM states IDLE, HOLD, LOCKOUT; reset state IDLE.
- IDLE: if `accept_en` and any press event or `ir_ready`: latch colour and `src`, go HOLD. Priority: keys over IR; among simultaneous key presses lowest index wins. Losers are drops.
- IDLE with `accept_en` low: all events are drops; state unchanged.
- HOLD: `cor_valid`=1, `cor_out`/`src` stable. `cor_ack` sampled high → LOCKOUT. `accept_en` low while in HOLD → event withdrawn (one drop), LOCKOUT. Any new event in HOLD is a drop.
- LOCKOUT: counter of width clog2(LOCKOUT_CYCLES+1) cleared on entry, increments each cycle, saturates. Exit to IDLE when counter == LOCKOUT_CYCLES and all four debounced keys released. Events in LOCKOUT are drops.
- `cor_ack` outside HOLD is ignored.
- `ir_cor` values are all legal; no range check.

## Timing
- Reset (async assert, sync release via flops already in design): `cor_out`=0, `cor_valid`=0, `src`=0, `busy`=0, `drop_cnt`=0, debounce and lockout counters 0.
- Key latency: raw edge → synchronised 2 cycles → debounced after DEBOUNCE_CYCLES further stable cycles → `cor_valid` high the cycle after the debounced edge.
- IR latency: `ir_ready` high at edge N (IDLE) → `cor_valid` high after edge N (visible cycle N+1).
- Ack: `cor_ack` high at edge M → `cor_valid` low and `busy` still high after edge M; earliest next `cor_valid` is M+LOCKOUT_CYCLES+2.
- `cor_ack` and `ir_ready` in the same cycle in HOLD: ack taken, IR is a drop.
- Reset mid-HOLD or mid-LOCKOUT: outputs to reset values immediately, pending event lost, not counted.

## Configuration
- `GENIUS_ARB_DROPCNT_EN` defined: `drop_cnt` increments by 1 per discarded event (multiple drops in one cycle count once per event, saturating at 255).
- Not defined: counter logic omitted, `drop_cnt` tied to 0; all other behaviour identical.

## Test plan
Run with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8, macro defined.
- `accept_en`=1, `key_n[2]` low steadily → `cor_valid` high 7 cycles after edge, `cor_out`=2, `src`=0; ack → `cor_valid` low next cycle.
- `key_n[1]` bounces (toggles every 2 cycles for 10 cycles) then low → exactly one event `cor_out`=1.
- `ir_ready` strobe with `ir_cor`=3 in IDLE → `cor_valid` next cycle, `cor_out`=3, `src`=1; second strobe 3 cycles after ack → dropped, `drop_cnt`=1.
- Debounced key 0 press and `ir_ready` (`ir_cor`=2) same cycle → `cor_out`=0, `src`=0, `drop_cnt`=1.
- Key held through lockout → stays in LOCKOUT (`busy`=1) past 8 cycles until release; no second event.
- `reset` asserted mid-HOLD → all outputs 0 within the same cycle; build without macro → `drop_cnt` constant 0.
